// File: rtl/led_sequencer_if.sv
// Control and LED bundle for led_sequencer.
// The master drives the controls and the slave (the sequencer) drives the LEDs.
interface led_sequencer_if #(
  parameter int unsigned W = 8
);
  logic         EN;
  logic         STEP;
  logic [1:0]   MODE;
  logic         LOAD;
  logic [W-1:0] LOAD_DATA;
  logic [W-1:0] LEDS;
  logic         TICK;
  logic         DIR;

  modport master (
    output EN, STEP, MODE, LOAD, LOAD_DATA,
    input  LEDS, TICK, DIR
  );

  modport slave (
    input  EN, STEP, MODE, LOAD, LOAD_DATA,
    output LEDS, TICK, DIR
  );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern generator with a built-in prescaler. It supports rotate, ping-pong
// and counter modes, plus run/stop, single-step and load. All outputs come straight from flops.
module led_sequencer #(
  parameter int unsigned     W    = 8,
  parameter int unsigned     N    = 21,
  parameter logic [W-1:0]    INIT = W'(8'h01)
) (
  input logic            CLK,
  input logic            RSTN,
  led_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_ROL  = 2'b00,
    MODE_ROR  = 2'b01,
    MODE_PING = 2'b10,
    MODE_CNT  = 2'b11
  } mode_e;

  logic [N-1:0] r_count;
  logic [W-1:0] r_leds;
  logic         r_dir;
  logic         r_tick;
  mode_e        r_mode;

  mode_e        w_mode;
  logic         w_step_req;
  logic [W-1:0] w_next_leds;
  logic         w_next_dir;
  logic [W-1:0] w_change_leds;

  assign w_mode        = mode_e'(bus.MODE);
  assign w_step_req    = bus.EN ? (r_count == '1) : bus.STEP;
  assign w_change_leds = (w_mode == MODE_CNT) ? '0 : INIT;

  // Next pattern when the mode does not change; ping-pong turns around on the step itself.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    w_next_leds = r_leds;
    w_next_dir  = r_dir;
    case (r_mode)
      MODE_ROL: w_next_leds = {r_leds[W-2:0], r_leds[W-1]};
      MODE_ROR: w_next_leds = {r_leds[0], r_leds[W-1:1]};
      MODE_PING: begin
        if (!r_dir && r_leds[W-1]) begin
          w_next_dir  = 1'b1;
          w_next_leds = r_leds >> 1;
        end else if (r_dir && r_leds[0]) begin
          w_next_dir  = 1'b0;
          w_next_leds = r_leds << 1;
        end else if (r_dir) begin
          w_next_leds = r_leds >> 1;
        end else begin
          w_next_leds = r_leds << 1;
        end
      end
      MODE_CNT: w_next_leds = r_leds + W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    if (!RSTN) begin
      r_count <= '0;
      r_leds  <= INIT;
      r_dir   <= 1'b0;
      r_tick  <= 1'b0;
      r_mode  <= MODE_ROL;
    end else if (bus.LOAD) begin
      // Load wins over a coincident step, and the prescaler restarts a full period.
      r_count <= '0;
      r_leds  <= bus.LOAD_DATA;
      r_dir   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_step_req;
      if (bus.EN) begin
        r_count <= r_count + N'(1);
      end
      if (w_step_req) begin
        if (w_mode != r_mode) begin
          r_leds <= w_change_leds;
          r_dir  <= 1'b0;
          r_mode <= w_mode;
        end else begin
          r_leds <= w_next_leds;
          r_dir  <= w_next_dir;
        end
      end
    end
  end

  assign bus.LEDS = r_leds;
  assign bus.TICK = r_tick;
  assign bus.DIR  = r_dir;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: a reference model predicts every step, and a TICK-driven monitor
// checks the predicted cycle, pattern and direction in order. The stimulus is directed, then random.
module tb_led_sequencer;

  localparam int W    = 8;
  localparam int N    = 3;
  localparam int INIT = 8'h01;
  localparam int MASK = (1 << W) - 1;
  localparam int PER  = 1 << N;

  typedef struct {
    int cyc;
    int leds;
    int dir;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  led_sequencer_if #(.W(W)) bus ();

  led_sequencer #(.W(W), .N(N), .INIT(8'h01)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;
  int   neg_n    = 0;
  exp_t sb[$];

  // Reference state: the pattern, direction and committed mode, plus the count of
  // enabled cycles since the prescaler last restarted.
  int m_leds = INIT;
  int m_dir  = 0;
  int m_mode = 0;
  int m_en_cycles = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic void apply_step(input int mode);
    int msb;
    int lsb;
    msb = (m_leds >> (W - 1)) & 1;
    lsb = m_leds & 1;
    if (mode != m_mode) begin
      m_mode = mode;
      m_dir  = 0;
      m_leds = (mode == 3) ? 0 : INIT;
    end else begin
      case (mode)
        0: m_leds = ((m_leds << 1) | msb) & MASK;
        1: m_leds = (m_leds >> 1) | (lsb << (W - 1));
        2: begin
          if (m_dir == 0 && msb == 1) m_dir = 1;
          else if (m_dir == 1 && lsb == 1) m_dir = 0;
          m_leds = (m_dir == 1) ? (m_leds >> 1) : ((m_leds << 1) & MASK);
        end
        default: m_leds = (m_leds + 1) % (1 << W);
      endcase
    end
  endfunction

  // Advance the model over one rising edge using the inputs currently applied.
  function automatic void model_edge();
    bit req;
    if (!rstn) begin
      m_leds = INIT; m_dir = 0; m_mode = 0; m_en_cycles = 0;
    end else if (bus.LOAD) begin
      m_leds = int'(bus.LOAD_DATA); m_dir = 0; m_en_cycles = 0;
    end else begin
      req = bus.EN ? ((m_en_cycles % PER) == PER - 1) : bus.STEP;
      if (bus.EN) m_en_cycles++;
      if (req) begin
        apply_step(int'(bus.MODE));
        sb.push_back('{cyc: edge_n, leds: m_leds, dir: m_dir});
      end
    end
  endfunction

  task automatic clock();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    repeat (n) clock();
    check("reset_leds", int'(bus.LEDS), INIT);
    check("reset_dir", int'(bus.DIR), 0);
    check("reset_tick", int'(bus.TICK), 0);
    rstn = 1'b1;
  endtask

  task automatic pulse_step();
    bus.STEP = 1'b1;
    clock();
    bus.STEP = 1'b0;
    clock();
  endtask

  // The monitor pops one expectation per TICK and flags any step that was predicted but never shown.
  always @(negedge clk) begin
    exp_t e;
    neg_n++;
    if (bus.TICK === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        e = sb.pop_front();
        check("tick_cycle", neg_n, e.cyc);
        check("tick_leds", int'(bus.LEDS), e.leds);
        check("tick_dir", int'(bus.DIR), e.dir);
      end
    end else if (sb.size() > 0 && sb[0].cyc <= neg_n) begin
      e = sb.pop_front();
      check("missed_tick", neg_n, e.cyc);
    end
  end

  initial begin
    rstn = 1'b0;
    bus.EN = 1'b0; bus.STEP = 1'b0; bus.MODE = 2'b00;
    bus.LOAD = 1'b0; bus.LOAD_DATA = '0;

    // Free-run rotate left through a full revolution.
    do_reset(2);
    bus.EN = 1'b1;
    repeat (PER * 9) clock();

    // A load on the same edge as a prescaler tick wins, and the period restarts.
    while ((m_en_cycles % PER) != PER - 1) clock();
    bus.LOAD = 1'b1; bus.LOAD_DATA = 8'hAA;
    clock();
    bus.LOAD = 1'b0;
    check("load_leds", int'(bus.LEDS), 8'hAA);
    check("load_tick", int'(bus.TICK), 0);
    repeat (PER * 3) clock();

    // Rotate right from reset: the first tick is a mode change.
    bus.MODE = 2'b01;
    do_reset(1);
    repeat (PER * 5) clock();

    // Ping-pong for more than a full bounce.
    bus.MODE = 2'b10;
    do_reset(1);
    repeat (PER * 16) clock();

    // A mid-run reset while moving right at 0x20.
    for (int i = 0; i < 400 && !(m_leds == 8'h20 && m_dir == 1); i++) clock();
    check("pp_reach_leds", int'(bus.LEDS), 8'h20);
    check("pp_reach_dir", int'(bus.DIR), 1);
    do_reset(1);
    repeat (PER * 2) clock();

    // Manual stepping of the counter, including all-ones wrapping to zero.
    bus.EN = 1'b0; bus.MODE = 2'b11;
    bus.LOAD = 1'b1; bus.LOAD_DATA = 8'hFE;
    clock();
    bus.LOAD = 1'b0;
    check("man_load", int'(bus.LEDS), 8'hFE);
    repeat (3) pulse_step();
    bus.LOAD = 1'b1;
    clock();
    bus.LOAD = 1'b0;
    repeat (2) pulse_step();
    bus.STEP = 1'b1;
    repeat (3) clock();
    bus.STEP = 1'b0;
    repeat (5) clock();
    check("frozen_hold", int'(bus.LEDS), m_leds);
    bus.EN = 1'b1;
    repeat (PER * 3) clock();

    // Random controls, including random load patterns in every mode.
    for (int i = 0; i < 1500; i++) begin
      rstn          = ($urandom_range(0, 299) != 0);
      bus.LOAD      = ($urandom_range(0, 39) == 0);
      bus.LOAD_DATA = W'($urandom);
      bus.EN        = ($urandom_range(0, 3) != 0);
      bus.STEP      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) bus.MODE = 2'($urandom_range(0, 3));
      clock();
    end

    rstn = 1'b1; bus.EN = 1'b0; bus.STEP = 1'b0; bus.LOAD = 1'b0;
    repeat (4) clock();
    check("queue_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised LED pattern generator: a W-bit pattern register advanced once per prescaler tick, driving the board LEDs directly.
- Four selectable modes: rotate left, rotate right, ping-pong (bouncing dot) and binary up-counter.
- Adds run/stop, manual single-step and synchronous pattern load.
- Sits between the board clock and the LED pins. It contains its own N-bit prescaler, so no separate divider instance is needed.

Parameters:
- W, 8, pattern/LED width in bits (W >= 2).
- N, 21, prescaler width; a step tick occurs every 2^N CLK cycles (N >= 1).
- INIT, 8'h01, W-bit pattern loaded on reset and on a mode change.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RSTN  in  1  synchronous reset, active-low. Sampled on the CLK rising edge only.
- EN  in  1  1 = free-run from prescaler; 0 = prescaler frozen, pattern held.
- STEP  in  1  single-cycle pulse; advances pattern one step when EN=0. Ignored when EN=1.
- MODE  in  2  00 rotate left, 01 rotate right, 10 ping-pong, 11 binary count up.
- LOAD  in  1  synchronous load strobe.
- LOAD_DATA  in  W  value written to pattern on LOAD.
- LEDS  out  W  current pattern; LEDS[0] is the rightmost LED.
- TICK  out  1  high for exactly the one cycle in which a newly stepped LEDS value first appears.
- DIR  out  1  ping-pong direction: 0 = moving left (toward MSB), 1 = moving right.

Behaviour:
- Reset (RSTN=0 at an edge) sets:
  - LEDS=INIT, DIR=0, TICK=0
  - prescaler count=0
  - registered mode mode_q=2'b00
- Reset overrides every other input, including mid-step or mid-load.
- Prescaler:
  - N-bit counter increments each cycle while EN=1, and holds while EN=0.
  - step_req = EN & (count == 2^N-1); the counter wraps to 0 on that same edge.
  - The first step after reset with EN held high lands on edge number 2^N.
- Manual step: step_req = ~EN & STEP. One step per cycle in which STEP=1; STEP held high for k cycles gives k steps.
- Priority at each edge: RSTN, then LOAD, then step_req.
- LOAD:
  - LEDS=LOAD_DATA, DIR=0, prescaler count=0, TICK=0.
  - mode_q is unchanged.
  - A step_req in the same cycle is discarded.
- Step with MODE != mode_q:
  - Mode-change step: LEDS=INIT (MODE=11 loads all-zeros), DIR=0, mode_q=MODE, TICK=1 next cycle.
  - A MODE change between ticks has no effect until the next step.
- Step with MODE == mode_q:
  - 00: LEDS={LEDS[W-2:0], LEDS[W-1]}.
  - 01: LEDS={LEDS[0], LEDS[W-1:1]}.
  - 10, ping-pong, logical shift with zero fill:
    - If DIR=0 and LEDS[W-1]=1: DIR=1, LEDS=LEDS>>1.
    - Else if DIR=1 and LEDS[0]=1: DIR=0, LEDS=LEDS<<1.
    - Else shift in the current DIR.
    - Turnaround happens on the step itself (no dwell), so the period for a one-hot start is 2(W-1) steps.
    - An all-zero pattern stays zero.
  - 11: LEDS=LEDS+1 modulo 2^W; all-ones wraps to 0.
- DIR changes only in mode 10, on reset, on LOAD, or on a mode-change step. It holds its value in other modes.
- TICK is registered: it equals 1 in the cycle after any step_req edge that was not overridden by LOAD or reset.
- Latency: LEDS updates on the step edge; TICK is coincident with the new value.
- No combinational path exists from any input to any output.

Test Plan:
All scenarios use W=8, N=3, INIT=8'h01, MODE=00 at reset unless stated.
1. RSTN=0 for 2 cycles, then EN=1 -> LEDS=01 and DIR=0 during reset; first change at edge 8 after release gives LEDS=02 with TICK high 1 cycle; then 04, 08 every 8 cycles; 80 steps to 01.
2. MODE=01 from reset, EN=1 -> first tick is a mode-change step with LEDS=01; subsequent ticks 80, 40, 20, ...
3. MODE=10, EN=1, run 16 ticks -> LEDS sequence 01 (mode change), 02, 04, ..., 80, 40, ..., 01, 02. DIR=1 from the 80->40 step until the 02->01 step, and DIR=0 at 01->02.
4. MODE=11, EN=0, LOAD=1 with LOAD_DATA=FE, then 3 STEP pulses:
   - first STEP is a mode change -> LEDS=00;
   - LOAD again with FE, then 2 STEPs -> LEDS=FF, then 00 (wrap);
   - TICK high after each STEP;
   - prescaler count stays frozen throughout.
5. EN=1 with LOAD asserted on the same edge as a prescaler tick, LOAD_DATA=AA -> LEDS=AA, no TICK, next step exactly 8 cycles later.
6. Mid-run (ping-pong, DIR=1, LEDS=20) assert RSTN=0 for 1 edge -> LEDS=01, DIR=0, TICK=0. With MODE still 10, the next tick is a mode-change step -> LEDS=01, TICK=1.
